// File: rtl/frame_write_ctrl_pkg.sv
// Display geometry and write-controller state encoding, shared with the
// scanner and framebuffer.
package frame_write_ctrl_pkg;

  localparam int unsigned DISP_WIDTH  = 32;
  localparam int unsigned DISP_HEIGHT = 16;
  localparam int unsigned DISP_ADDR_W = 9;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRecv     = 2'd1,
    StFlipWait = 2'd2
  } wr_state_e;

endpackage

// File: rtl/frame_write_ctrl_pixel_packer.sv
// Collects three received bytes into one 24-bit pixel and strobes when the
// third byte arrives.
module pixel_packer
  import frame_write_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [1:0]  byte_idx,
  output logic [23:0] pixel,
  output logic        pix_stb
);

  logic [1:0] idx_q, idx_d, idx_eff;
  logic [7:0] b0_q, b0_d, b1_q, b1_d;

  always_comb begin
    // A frame-start byte is always byte0, whatever the index held.
    idx_eff = start ? 2'd0 : idx_q;
    idx_d   = idx_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    pix_stb = 1'b0;
    if (take) begin
      if (idx_eff == 2'd0) begin
        b0_d  = data;
        idx_d = 2'd1;
      end else if (idx_eff == 2'd1) begin
        b1_d  = data;
        idx_d = 2'd2;
      end else begin
        pix_stb = 1'b1;
        idx_d   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= 2'd0;
      b0_q  <= 8'd0;
      b1_q  <= 8'd0;
    end else begin
      idx_q <= idx_d;
      b0_q  <= b0_d;
      b1_q  <= b1_d;
    end
  end

  // byte2 passes straight through; it is only needed on the strobe cycle.
  assign pixel    = {b0_q, b1_q, data};
  assign byte_idx = idx_q;

endmodule

// File: rtl/frame_write_ctrl.sv
// Double-buffered framebuffer write sequencer: packs SPI bytes into pixels,
// writes the back bank and flips banks at vblank after a clean frame.
module frame_write_ctrl
  import frame_write_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DISP_WIDTH,
  parameter int unsigned HEIGHT = DISP_HEIGHT,
  parameter int unsigned ADDR_W = DISP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data,
  input  logic              valid,
  input  logic              sot,
  input  logic              eot,
  input  logic              vblank,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [23:0]       wr_data,
  output logic              front_buf,
  output logic              busy,
  output logic              frame_err
);

  localparam logic [ADDR_W:0] NumPix = (ADDR_W + 1)'(WIDTH * HEIGHT);

  wr_state_e       state_q, state_d;
  logic            front_q, front_d;
  logic            err_q, err_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            eot_q;
  logic            wr_en_q, wr_en_d;
  logic [ADDR_W:0] wr_addr_q, wr_addr_d;
  logic [23:0]     wr_data_q, wr_data_d;

  logic            start, take, eot_rise, pix_stb;
  logic [1:0]      byte_idx;
  logic [23:0]     pixel;

  pixel_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .take     (take),
    .data     (data),
    .byte_idx (byte_idx),
    .pixel    (pixel),
    .pix_stb  (pix_stb)
  );

  assign eot_rise = eot & ~eot_q;

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start     = 1'b0;
    take      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          start   = 1'b1;
          take    = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (valid && sot) begin
          start = 1'b1;
          take  = 1'b1;
          err_d = 1'b0;
          cnt_d = '0;
        end else if (eot_rise) begin
          if (cnt_q == NumPix && byte_idx == 2'd0 && !err_q) begin
            state_d = StFlipWait;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else if (valid) begin
          take = 1'b1;
        end
        if (pix_stb) begin
          if (cnt_q == NumPix) begin
            err_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = {~front_q, cnt_q[ADDR_W-1:0]};
            wr_data_d = pixel;
            cnt_d     = cnt_q + 1'b1;
          end
        end
      end
      StFlipWait: begin
        if (valid) err_d = 1'b1;
        if (vblank) begin
          front_d = ~front_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      front_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      eot_q     <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      eot_q     <= eot;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign front_buf = front_q;
  assign busy      = (state_q == StFlipWait);
  assign frame_err = err_q;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Self-checking bench for frame_write_ctrl: byte streams are checked against
// pixels predicted directly from the byte list.
module tb_frame_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        valid = 1'b0;
  logic        sot = 1'b0;
  logic        eot = 1'b1;
  logic        vblank = 1'b0;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [23:0] wr_data;
  logic        front_buf;
  logic        busy;
  logic        frame_err;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [9:0]  wa_q[$];
  logic [23:0] wd_q[$];
  logic [7:0]  bq[$];
  logic        exp_front = 1'b0;

  frame_write_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .valid     (valid),
    .sot       (sot),
    .eot       (eot),
    .vblank    (vblank),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .front_buf (front_buf),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Random gap first so a completed pixel's write is visible on return.
  task automatic send_byte(input logic [7:0] b, input logic s);
    cyc($urandom_range(0, 1));
    data  = b;
    valid = 1'b1;
    sot   = s;
    cyc(1);
    valid = 1'b0;
    sot   = 1'b0;
  endtask

  task automatic pulse_vblank();
    vblank = 1'b1;
    cyc(1);
    vblank = 1'b0;
    cyc(1);
  endtask

  task automatic do_frame(input int n, input bit pattern, input logic first_sot);
    logic [7:0] b;
    eot = 1'b0;
    cyc(1);
    wa_q.delete();
    wd_q.delete();
    bq.delete();
    for (int i = 0; i < n; i++) begin
      b = pattern ? 8'(i % 256) : 8'($urandom);
      bq.push_back(b);
      send_byte(b, (i == 0) ? first_sot : 1'b0);
    end
    cyc(2);
    eot = 1'b1;
    cyc(3);
  endtask

  // Expected writes: pixel k is bytes 3k..3k+2, at most WIDTH*HEIGHT of them.
  task automatic check_writes(input string tag, input int nbytes, input logic bank);
    int npix;
    int lim;
    logic [31:0] ea;
    logic [31:0] ed;
    npix = nbytes / 3;
    if (npix > 512) npix = 512;
    chk({tag, "_count"}, 32'(wa_q.size()), 32'(npix));
    lim = (wa_q.size() < npix) ? wa_q.size() : npix;
    for (int i = 0; i < lim; i++) begin
      ea = (32'(bank) << 9) + 32'(i);
      ed = {8'd0, bq[3*i], bq[3*i+1], bq[3*i+2]};
      chk({tag, "_addr"}, 32'(wa_q[i]), ea);
      chk({tag, "_data"}, 32'(wd_q[i]), ed);
    end
  endtask

  initial begin
    // Reset with eot held high.
    rst = 1'b0;
    eot = 1'b1;
    cyc(3);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_front", 32'(front_buf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b1;
    cyc(3);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // First transfer after reset: no sot, eot still high on the first byte.
    wa_q.delete();
    wd_q.delete();
    bq.delete();
    bq.push_back(8'd0);
    send_byte(8'd0, 1'b0);
    eot = 1'b0;
    for (int i = 1; i < 1536; i++) begin
      bq.push_back(8'(i % 256));
      send_byte(8'(i % 256), 1'b0);
    end
    cyc(2);
    eot = 1'b1;
    cyc(3);
    check_writes("first", 1536, 1'b1);
    chk("first_pix0", (wd_q.size() > 0) ? 32'(wd_q[0]) : 32'hffff_ffff, 32'h0000_0102);
    chk("first_busy", 32'(busy), 32'd1);
    chk("first_err", 32'(frame_err), 32'd0);
    chk("first_front_pre", 32'(front_buf), 32'd0);
    pulse_vblank();
    exp_front = ~exp_front;
    chk("first_front_post", 32'(front_buf), 32'(exp_front));
    chk("first_busy_post", 32'(busy), 32'd0);

    // vblank in IDLE does nothing.
    pulse_vblank();
    chk("idle_vblank_front", 32'(front_buf), 32'(exp_front));

    // Random full frame, then bytes during FLIP_WAIT.
    do_frame(1536, 1'b0, 1'b1);
    check_writes("rand", 1536, ~exp_front);
    chk("rand_busy", 32'(busy), 32'd1);
    chk("rand_err", 32'(frame_err), 32'd0);
    wa_q.delete();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    cyc(2);
    chk("bw_writes", 32'(wa_q.size()), 32'd0);
    chk("bw_err", 32'(frame_err), 32'd1);
    chk("bw_busy", 32'(busy), 32'd1);
    chk("bw_front_hold", 32'(front_buf), 32'(exp_front));
    pulse_vblank();
    exp_front = ~exp_front;
    chk("bw_front_post", 32'(front_buf), 32'(exp_front));
    chk("bw_busy_post", 32'(busy), 32'd0);

    // Short frame.
    do_frame(1535, 1'b0, 1'b1);
    check_writes("short", 1535, ~exp_front);
    chk("short_err", 32'(frame_err), 32'd1);
    chk("short_busy", 32'(busy), 32'd0);
    pulse_vblank();
    chk("short_front", 32'(front_buf), 32'(exp_front));

    // Overflow frame.
    do_frame(1539, 1'b0, 1'b1);
    check_writes("ovf", 1539, ~exp_front);
    chk("ovf_err", 32'(frame_err), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd0);
    pulse_vblank();
    chk("ovf_front", 32'(front_buf), 32'(exp_front));

    // Next frame start clears the sticky error; then reset after 300 bytes.
    eot = 1'b0;
    cyc(1);
    send_byte(8'($urandom), 1'b1);
    cyc(1);
    chk("err_cleared", 32'(frame_err), 32'd0);
    for (int i = 1; i < 300; i++) send_byte(8'($urandom), 1'b0);
    chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_front", 32'(front_buf), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    cyc(2);
    rst = 1'b1;
    exp_front = 1'b0;
    cyc(2);
    do_frame(1536, 1'b1, 1'b1);
    check_writes("after_rst", 1536, 1'b1);
    chk("after_rst_err", 32'(frame_err), 32'd0);
    chk("after_rst_busy", 32'(busy), 32'd1);
    pulse_vblank();
    chk("after_rst_front", 32'(front_buf), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_write_ctrl.md
FRAME_WRITE_CTRL -- requirements
Module: frame_write_ctrl

Interface
REQ-001 Parameters: WIDTH=32 (pixels per row); HEIGHT=16 (rows); ADDR_W=9 (log2 of WIDTH*HEIGHT).
REQ-002 clk  in  1  single system clock; all logic on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 data  in  8  received byte from the SPI byte receiver; sampled only when valid=1.
REQ-005 valid  in  1  one-cycle strobe marking data as a new byte.
REQ-006 sot  in  1  start of transfer; coincides with valid on the first byte of a transfer.
REQ-007 eot  in  1  level; high while slave-select is deasserted.
REQ-008 vblank  in  1  one-cycle pulse from the display scanner at the frame boundary.
REQ-009 wr_en  out  1  framebuffer write strobe.
REQ-010 wr_addr  out  ADDR_W+1  {back bank bit, pixel index}.
REQ-011 wr_data  out  24  pixel as {byte0, byte1, byte2}.
REQ-012 front_buf  out  1  bank the scanner reads.
REQ-013 busy  out  1  high in FLIP_WAIT.
REQ-014 frame_err  out  1  sticky error flag; cleared at the next frame start.

Function
REQ-015 States: IDLE, RECV, FLIP_WAIT.
REQ-016 Frame start: valid=1 with sot=1 in IDLE or RECV, or the first valid=1 in IDLE regardless of sot (covers the first transfer after reset, which carries no sot).
REQ-017 Frame start actions: clear the byte index (0..2) and pixel count; clear frame_err; enter RECV; treat the byte as byte0 of pixel 0.
REQ-018 In RECV, each valid byte is stored at the current byte index, and the index advances 0->1->2->0.
REQ-019 On the valid cycle carrying byte2, the next cycle shall present wr_en=1 for exactly one cycle with the following values: wr_addr={~front_buf, pixel count}; wr_data={byte0, byte1, byte2}.
REQ-020 The pixel count increments after each write; it does not wrap.
REQ-021 Once the pixel count equals WIDTH*HEIGHT, further completed pixels shall not be written and shall set frame_err.
REQ-022 A rising edge of eot (registered previous value 0, current value 1) in RECV ends the frame.
REQ-023 End of frame with pixel count == WIDTH*HEIGHT, byte index == 0 and frame_err=0: enter FLIP_WAIT.
REQ-024 Any other end of frame (short frame, partial pixel or overflow): set frame_err, return to IDLE, no flip.
REQ-025 In FLIP_WAIT, on vblank=1: toggle front_buf in that same cycle's register update, then return to IDLE.
REQ-026 In FLIP_WAIT, valid bytes shall be discarded and frame_err set; sot is ignored.
REQ-027 A vblank outside FLIP_WAIT shall have no effect.
REQ-028 eot level, or its rising edge, in IDLE or FLIP_WAIT shall have no effect.
REQ-029 The controller shall never write to bank front_buf.

Reset
REQ-030 While rst=0, the following shall hold: state=IDLE; wr_en=0; wr_addr=0; wr_data=0; front_buf=0; busy=0; frame_err=0; byte index=0; pixel count=0; eot edge register=1.
REQ-031 The eot edge register resets to 1 so that eot held high out of reset does not produce an end-of-frame event.
REQ-032 Reset mid-frame or in FLIP_WAIT shall abandon the frame with no flip and no further writes.

Structure
REQ-033 WIDTH, HEIGHT, ADDR_W and the state encodings shall live in a shared display-constants include used by the scanner and framebuffer.
REQ-034 One sub-module, pixel_packer, shall hold the byte index and the 24-bit assembly and emit a pixel strobe; sequencing stays in frame_write_ctrl.

Verification
REQ-035 Full frame: sot with 1536 bytes of pattern n%256, eot, then vblank -> 512 writes to bank 1; addresses 0..511 in order; first wr_data=0x000102; front_buf 0->1 on vblank; frame_err=0.
REQ-036 Short frame: 1535 bytes then eot -> 511 writes; frame_err=1; state IDLE; front_buf unchanged.
REQ-037 Overflow: 1539 bytes then eot -> exactly 512 writes; frame_err=1; no flip.
REQ-038 Busy window: after a full frame, send 3 bytes before vblank -> no writes; frame_err=1; busy=1 until vblank, then front_buf toggles.
REQ-039 Post-reset start: release rst with eot=1, then bytes with sot=0 -> no spurious end-of-frame; first byte treated as pixel 0 byte0.
REQ-040 Mid-frame reset: assert rst after 300 bytes -> wr_en=0 immediately; front_buf=0; a following full frame writes bank 1 from address 0.
